// File: rtl/nx_fifo_rd_stream_if.sv
// nx_fifo_rd_stream_if: FIFO read port plus downstream valid/ready stream.
// master is the adapter's view, slave is the FIFO/consumer side.
interface nx_fifo_rd_stream_if #(
    parameter int WIDTH = 71
);
    logic             fifo_empty;
    logic             fifo_ren;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rerr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        input  fifo_empty, fifo_rdata, fifo_rerr, out_ready,
        output fifo_ren, out_valid, out_data, out_err
    );

    modport slave (
        output fifo_empty, fifo_rdata, fifo_rerr, out_ready,
        input  fifo_ren, out_valid, out_data, out_err
    );
endinterface

// File: rtl/nx_fifo_rd_stream.sv
// nx_fifo_rd_stream: pops a fixed-latency FIFO read port into a credit-tracked
// skid buffer and presents it as a first-word-fall-through valid/ready stream.
// ECC errors are tagged per word, optionally dropped, and counted.
module nx_fifo_rd_stream #(
    parameter int WIDTH     = 71,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4,
    parameter int DROP_ERR  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    nx_fifo_rd_stream_if.master        bus,
    input  logic                       clear,
    input  logic                       err_clr,
    output logic                       err_sticky,
    output logic [15:0]                err_cnt,
    output logic [$clog2(BUF_DEPTH):0] occupancy
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    // keep a 1-bit shift register when RD_LAT=0; it is held at zero
    localparam int LW = (RD_LAT == 0) ? 1 : RD_LAT;

    logic [WIDTH:0]  mem [BUF_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [LW-1:0]   inflight;
    logic [LW-1:0]   kill;

    logic            ren;
    logic [CW-1:0]   used;
    logic            ret_slot;
    logic            ret_kill;
    logic            ret_live;
    logic            do_wr;
    logic            do_pop;
    logic            err_hit;
    logic [LW-1:0]   inflight_n;
    logic [LW-1:0]   kill_n;
    logic [CW-1:0]   count_n;
    logic [CW-1:0]   occ_n;

    function automatic logic [CW-1:0] popcnt(input logic [LW-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < LW; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Credit check, issue, return qualification and next-state of the counters.
    always_comb begin
        used       = count + popcnt(inflight);
        ren        = !bus.fifo_empty && (used < CW'(BUF_DEPTH)) && !clear && !rst;
        ret_slot   = 1'b0;
        ret_kill   = 1'b0;
        inflight_n = '0;
        kill_n     = '0;
        if (RD_LAT == 0) begin
            ret_slot = ren;
        end else begin
            ret_slot   = inflight[LW-1];
            ret_kill   = kill[LW-1];
            inflight_n = (inflight << 1) | LW'(ren);
            // ren is low during clear, so only pre-existing reads get killed
            kill_n     = clear ? (inflight << 1) : (kill << 1);
        end
        // a word landing in the clear cycle is dropped along with the buffer
        ret_live = ret_slot && !ret_kill && !clear;
        err_hit  = ret_live && bus.fifo_rerr;
        do_wr    = ret_live && !((DROP_ERR != 0) && bus.fifo_rerr);
        do_pop   = (count != '0) && bus.out_ready;
        count_n  = count;
        if (clear) begin
            count_n = '0;
        end else if (do_wr && !do_pop) begin
            count_n = count + CW'(1);
        end else if (!do_wr && do_pop) begin
            count_n = count - CW'(1);
        end
        occ_n = count_n + popcnt(inflight_n);
    end

    // Buffer storage, pointers, credit state and registered occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            inflight  <= '0;
            kill      <= '0;
            occupancy <= '0;
        end else begin
            inflight  <= inflight_n;
            kill      <= kill_n;
            count     <= count_n;
            occupancy <= occ_n;
            if (do_wr) begin
                mem[wptr] <= {bus.fifo_rerr, bus.fifo_rdata};
                wptr      <= wptr + AW'(1);
            end
            if (clear) begin
                rptr <= wptr;
            end else if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    // ECC error sticky flag and saturating counter; err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_hit) begin
            err_sticky <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign bus.fifo_ren                 = ren;
    assign bus.out_valid                = (count != '0);
    assign {bus.out_err, bus.out_data}  = mem[rptr];
endmodule
